// File: rtl/xc_malu_pmul_seq_if.sv
// Issue-side handshake bundle for the packed-multiply sequencer: operation
// request, synchronous flush and result return.
interface xc_malu_pmul_seq_if;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op_pw;
    logic        op_high;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport master (
        output op_valid, op_pw, op_high, op_rs1, op_rs2, flush, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_pw, op_high, op_rs1, op_rs2, flush, res_ready,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/xc_malu_pmul_seq.sv
// Sequencer for the packed shift-add multiply: owns the counter, accumulator
// and argument registers and unpacks the low/high lane halves into the result.
module xc_malu_pmul_seq (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    xc_malu_pmul_seq_if.slave    bus,
    output logic [31:0]          step_rs1,
    output logic [4:0]           step_pw,
    output logic [5:0]           step_counter,
    output logic [63:0]          step_accumulator,
    output logic [31:0]          step_argument,
    input  logic [63:0]          step_n_accumulator,
    input  logic [32:0]          step_n_argument,
    input  logic                 step_finished,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        high_q;
    logic [31:0] res_q;
    logic [31:0] unpacked;
    logic        accept;
    logic        pw_ok;
    logic        unused_arg_msb;

    // The step block's carry-out of the argument shift is never needed.
    assign unused_arg_msb = step_n_argument[32];

    assign accept = bus.op_valid & bus.op_ready;
    // Only a single width select in bits 4:1 is runnable; anything else
    // short-circuits to a zero result.
    assign pw_ok  = ~bus.op_pw[0] & $onehot(bus.op_pw[4:1]);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.op_valid) state_nxt = pw_ok ? S_RUN : S_DONE;
            S_RUN: begin
                if (bus.flush)          state_nxt = S_IDLE;
                else if (step_finished) state_nxt = S_DONE;
            end
            S_DONE: if (bus.res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.op_ready  = (state == S_IDLE);
        bus.res_valid = (state == S_DONE);
        busy          = (state != S_IDLE);
    end

    assign bus.res_data = res_q;

    // Lane W of the result comes from the matching 2W-bit accumulator lane.
    always_comb begin
        unpacked = '0;
        case (step_pw)
            5'b00010: for (int l = 0; l < 2; l++)
                unpacked[16*l +: 16] = high_q ? step_accumulator[32*l+16 +: 16]
                                              : step_accumulator[32*l    +: 16];
            5'b00100: for (int l = 0; l < 4; l++)
                unpacked[8*l +: 8]   = high_q ? step_accumulator[16*l+8 +: 8]
                                              : step_accumulator[16*l   +: 8];
            5'b01000: for (int l = 0; l < 8; l++)
                unpacked[4*l +: 4]   = high_q ? step_accumulator[8*l+4 +: 4]
                                              : step_accumulator[8*l   +: 4];
            5'b10000: for (int l = 0; l < 16; l++)
                unpacked[2*l +: 2]   = high_q ? step_accumulator[4*l+2 +: 2]
                                              : step_accumulator[4*l   +: 2];
            default: unpacked = '0;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            step_rs1         <= '0;
            step_pw          <= '0;
            step_counter     <= '0;
            step_accumulator <= '0;
            step_argument    <= '0;
            high_q           <= 1'b0;
            res_q            <= '0;
        end else if (accept) begin
            step_rs1         <= bus.op_rs1;
            step_pw          <= bus.op_pw;
            high_q           <= bus.op_high;
            step_accumulator <= '0;
            step_argument    <= bus.op_rs2;
            step_counter     <= '0;
            if (!pw_ok) res_q <= '0;
        end else if (state == S_RUN && !bus.flush) begin
            if (step_finished) begin
                res_q <= unpacked;
            end else begin
                step_accumulator <= step_n_accumulator;
                step_argument    <= step_n_argument[31:0];
                // Saturate so a stuck step block cannot alias the count.
                if (step_counter != 6'h3f) step_counter <= step_counter + 6'd1;
            end
        end
    end

endmodule

// File: doc/xc_malu_pmul_seq.md
Name: xc_malu_pmul_seq

Overview:
Sequential controller that drives the combinational packed-multiply step datapath (pmul/pmulh) and the shared packed adder.
- Owns the counter, accumulator and argument registers that the step block reads.
- Accepts an operation over a valid/ready handshake, iterates one shift-add step per cycle, then unpacks and returns the low (pmul) or high (pmulh) lane halves over a second valid/ready handshake.
- Sits inside the MALU between instruction issue and the step/adder logic.

Parameters:
None. Datapath widths are fixed: 32-bit operands, 64-bit accumulator.

Ports:
g_clk  in  1  clock; all state updates on the rising edge
g_resetn  in  1  asynchronous active-low reset
op_valid  in  1  operation request
op_ready  out  1  high only in IDLE; acceptance = op_valid & op_ready
op_pw  in  5  one-hot pack width; bit1=16, bit2=8, bit3=4, bit4=2
op_high  in  1  0=pmul (low halves), 1=pmulh (high halves)
op_rs1  in  32  multiplicand lanes
op_rs2  in  32  multiplier lanes
flush  in  1  synchronous abort of an in-flight operation
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  32  packed result
step_rs1  out  32  latched rs1 presented to the step block
step_pw  out  5  latched pw presented to the step block
step_counter  out  6  iteration counter
step_accumulator  out  64  accumulator register
step_argument  out  32  argument register (shifted multiplier)
step_n_accumulator  in  64  next accumulator from the step block
step_n_argument  in  33  next argument from the step block; bit 32 ignored
step_finished  in  1  step block reports counter == lane width
busy  out  1  state != IDLE

Behaviour:
Reset (async, g_resetn low):
- State = IDLE.
- op_ready=1, res_valid=0, res_data=0, busy=0.
- step_counter=0, step_accumulator=0, step_argument=0, step_rs1=0, step_pw=0.
- Internal high flag = 0.
- Reset mid-operation discards all work; no result is produced.

States:
- IDLE:
  - op_ready=1.
  - On acceptance: latch rs1, pw, high; accumulator=0; argument=op_rs2; counter=0.
  - If pw is one-hot in bits 4:1, go to RUN.
  - Otherwise (zero, multi-hot, or bit0 set), go to DONE with res_data=0.
- RUN, each cycle:
  - flush=1: go to IDLE. Registers keep their values; no result.
  - Else if step_finished=1: capture res_data from the accumulator (unpack below), go to DONE. Accumulator, argument and counter are not updated.
  - Else: accumulator<=step_n_accumulator, argument<=step_n_argument[31:0], counter<=counter+1.
- DONE:
  - res_valid=1; res_data is held stable until the handshake.
  - When res_ready=1, go to IDLE at the next edge.
  - op_ready=0 in DONE, so a new request cannot overlap.
  - flush is ignored in DONE and IDLE.

Latency:
- W = lane width (16/8/4/2).
- res_valid rises W+1 cycles after the accepting edge.
- Back-to-back throughput is one operation per W+3 cycles with res_ready held high.

Unpack (each 2W-bit accumulator lane L, for L = 0 .. 32/W-1):
- pmul: res_data lane L = accumulator[2W*L+W-1 : 2W*L].
- pmulh: res_data lane L = accumulator[2W*L+2W-1 : 2W*L+W].
- Each product is taken modulo 2^(2W). Carries never cross lanes.

Counter:
- 6 bits, never wraps. RUN exits at 16 at most.
- If step_finished never asserts, the block stays in RUN; only flush or reset recovers.

Test Plan:
The bench connects the existing step block and packed adder to the step_* ports.
1. pw=16, pmul, rs1=0x0003FFFF, rs2=0x0005FFFF -> res_data=0x000F0001, res_valid 17 cycles after acceptance. Same operands with pmulh -> 0x0000FFFE.
2. pw=8, rs1=0x1020FF02, rs2=0x1008FF03 -> pmul 0x00000106, pmulh 0x0101FE00, latency 9.
3. pw=2, rs1=rs2=0xFFFFFFFF -> pmul 0x55555555, pmulh 0xAAAAAAAA, latency 3. pw=4, rs1=rs2=0xFFFFFFFF -> pmul 0x11111111, pmulh 0xEEEEEEEE, latency 5.
4. Hold res_ready=0 for 10 cycles after res_valid -> res_valid and res_data stable, op_ready=0. Raise res_ready -> IDLE next cycle; a second op accepted immediately produces the correct result.
5. flush in the 5th RUN cycle of a pw=16 op -> IDLE next cycle, no res_valid. The next op returns a correct result.
6. g_resetn pulsed low mid-RUN (asynchronously, between edges) -> all outputs reach reset values without waiting for a clock edge. pw=5'b00110 accepted -> res_valid after 1 cycle with res_data=0.
